// File: rtl/fpu_op_sequencer_pkg.sv
// Shared types and constants for the FPU operation sequencer: opcodes, FSM states,
// IEEE-754 single-precision constants and the opcode-to-operand mapping.
package fpu_op_sequencer_pkg;

  typedef enum logic [1:0] {
    FPU_NOP      = 2'd0,
    FPU_FMA      = 2'd1,
    FPU_MULTIPLY = 2'd2,
    FPU_ADD      = 2'd3
  } fpu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_A = 3'd1,
    ST_SEND_B = 3'd2,
    ST_SEND_C = 3'd3,
    ST_WAIT   = 3'd4,
    ST_RESP   = 3'd5
  } fpu_seq_state_t;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } fpu_operands_t;

  // The FPU only computes A*B+C, so MUL adds zero and ADD multiplies by one.
  function automatic fpu_operands_t map_operands(input fpu_op_t op,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b,
                                                 input logic [31:0] c);
    fpu_operands_t res;
    case (op)
      FPU_FMA:      res = '{a: a,      b: b, c: c};
      FPU_MULTIPLY: res = '{a: a,      b: b, c: FP_ZERO};
      FPU_ADD:      res = '{a: FP_ONE, b: a, c: b};
      default:      res = '{a: FP_ZERO, b: FP_ZERO, c: FP_ZERO};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fpu_op_sequencer_if.sv
// Request, FPU-side and response signals of the FPU operation sequencer.
// The sequencer uses the slave modport; its environment uses master.
interface fpu_op_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int FW     = 32,
  parameter int ID_W   = $clog2(NUM_CH)
) ();

  logic [NUM_CH-1:0]    req_valid;
  logic [NUM_CH-1:0]    req_ready;
  logic [2*NUM_CH-1:0]  req_op;
  logic [FW*NUM_CH-1:0] req_a;
  logic [FW*NUM_CH-1:0] req_b;
  logic [FW*NUM_CH-1:0] req_c;

  logic                 fpu_start;
  logic [FW-1:0]        fpu_in;
  logic                 fpu_ready;
  logic [FW-1:0]        fpu_out;
  logic                 fpu_error;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_ch;
  logic [FW-1:0]        rsp_y;
  logic                 rsp_err;
  logic                 busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_c,
    input  fpu_ready, fpu_out, fpu_error,
    input  rsp_ready,
    output req_ready, fpu_start, fpu_in,
    output rsp_valid, rsp_ch, rsp_y, rsp_err, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_c,
    output fpu_ready, fpu_out, fpu_error,
    output rsp_ready,
    input  req_ready, fpu_start, fpu_in,
    input  rsp_valid, rsp_ch, rsp_y, rsp_err, busy
  );

endinterface

// File: rtl/fpu_op_sequencer_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the last granted channel
// and advances its pointer only when the grant is actually taken.
module fpu_op_sequencer_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_grant_en,
  output logic [NUM_CH-1:0] o_grant,
  output logic [ID_W-1:0]   o_grant_id,
  output logic              o_any
);

  logic [ID_W-1:0] r_last;
  logic [ID_W-1:0] w_idx;
  logic [ID_W-1:0] w_grant_id;
  logic            w_found;
  logic            w_hit;

  // Rotating priority search starting one past the last grant.
  always_comb begin
    w_idx      = '0;
    w_hit      = 1'b0;
    w_found    = 1'b0;
    w_grant_id = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx      = ID_W'((int'(r_last) + 1 + i) % NUM_CH);
      w_hit      = !w_found && i_req[w_idx];
      w_grant_id = w_hit ? w_idx : w_grant_id;
      w_found    = w_found | w_hit;
    end
  end

  assign o_grant    = w_found ? (NUM_CH'(1) << w_grant_id) : '0;
  assign o_grant_id = w_grant_id;
  assign o_any      = w_found;

  // Pointer starts at the last channel so channel 0 wins first after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= ID_W'(NUM_CH - 1);
    end else if (i_grant_en && w_found) begin
      r_last <= w_grant_id;
    end else begin
      r_last <= r_last;
    end
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Multi-channel front end for the serial-operand FMA-only FPU: arbitrates requests,
// streams three operands, waits for the result with a timeout and returns a tagged response.
module fpu_op_sequencer
  import fpu_op_sequencer_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int FW      = 32,
  parameter int TIMEOUT = 64,
  parameter int ID_W    = $clog2(NUM_CH)
) (
  input logic               clk,
  input logic               rst,
  fpu_op_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fpu_seq_state_t  r_state;
  fpu_seq_state_t  w_next_state;

  logic [NUM_CH-1:0] w_grant;
  logic [ID_W-1:0]   w_grant_id;
  logic              w_any_req;
  logic              w_accept;
  logic              w_timeout;

  fpu_op_t         w_sel_op;
  logic [FW-1:0]   w_sel_a;
  logic [FW-1:0]   w_sel_b;
  logic [FW-1:0]   w_sel_c;
  fpu_operands_t   w_map;

  logic [FW-1:0]   r_opa;
  logic [FW-1:0]   r_opb;
  logic [FW-1:0]   r_opc;
  logic [ID_W-1:0] r_ch;
  logic [CNT_W-1:0] r_cnt;
  logic [FW-1:0]   r_rsp_y;
  logic            r_rsp_err;
  logic [FW-1:0]   w_fpu_in;

  assign w_accept  = (r_state == ST_IDLE) && w_any_req;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  fpu_op_sequencer_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (bus.req_valid),
    .i_grant_en (w_accept),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id),
    .o_any      (w_any_req)
  );

  assign w_sel_op = fpu_op_t'(bus.req_op[w_grant_id*2 +: 2]);
  assign w_sel_a  = bus.req_a[w_grant_id*FW +: FW];
  assign w_sel_b  = bus.req_b[w_grant_id*FW +: FW];
  assign w_sel_c  = bus.req_c[w_grant_id*FW +: FW];
  assign w_map    = map_operands(w_sel_op, 32'(w_sel_a), 32'(w_sel_b), 32'(w_sel_c));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; NOP skips the FPU entirely.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = (w_sel_op == FPU_NOP) ? ST_RESP : ST_SEND_A;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SEND_A: w_next_state = ST_SEND_B;
      ST_SEND_B: w_next_state = ST_SEND_C;
      ST_SEND_C: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (bus.fpu_ready || w_timeout) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Operand latch, wait counter and response capture (ready beats timeout).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_opa     <= '0;
      r_opb     <= '0;
      r_opc     <= '0;
      r_ch      <= '0;
      r_cnt     <= '0;
      r_rsp_y   <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_opa     <= FW'(w_map.a);
            r_opb     <= FW'(w_map.b);
            r_opc     <= FW'(w_map.c);
            r_ch      <= w_grant_id;
            r_rsp_y   <= '0;
            r_rsp_err <= 1'b0;
          end
        end
        ST_SEND_C: r_cnt <= '0;
        ST_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (bus.fpu_ready) begin
            r_rsp_y   <= bus.fpu_out;
            r_rsp_err <= bus.fpu_error;
          end else if (w_timeout) begin
            r_rsp_y   <= FW'(FP_QNAN);
            r_rsp_err <= 1'b1;
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Serial operand bus is driven only in the three SEND states.
  always_comb begin
    w_fpu_in = '0;
    case (r_state)
      ST_SEND_A: w_fpu_in = r_opa;
      ST_SEND_B: w_fpu_in = r_opb;
      ST_SEND_C: w_fpu_in = r_opc;
      default:   w_fpu_in = '0;
    endcase
  end

  assign bus.req_ready = (r_state == ST_IDLE) ? w_grant : '0;
  assign bus.fpu_start = (r_state == ST_SEND_A);
  assign bus.fpu_in    = w_fpu_in;
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_ch    = r_ch;
  assign bus.rsp_y     = r_rsp_y;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed self-checking bench for fpu_op_sequencer; the FPU is modelled by the
// stimulus code, which raises fpu_ready with hand-chosen results.
module tb_fpu_op_sequencer;
  import fpu_op_sequencer_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int FW      = 32;
  localparam int TIMEOUT = 64;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fpu_op_sequencer_if #(.NUM_CH(NUM_CH), .FW(FW), .ID_W(ID_W)) bus ();

  fpu_op_sequencer #(
    .NUM_CH  (NUM_CH),
    .FW      (FW),
    .TIMEOUT (TIMEOUT),
    .ID_W    (ID_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input fpu_op_t op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    bus.req_valid[ch]          = 1'b1;
    bus.req_op[ch*2 +: 2]      = op;
    bus.req_a[ch*FW +: FW]     = a;
    bus.req_b[ch*FW +: FW]     = b;
    bus.req_c[ch*FW +: FW]     = c;
  endtask

  // Full operation: accept, three operand beats, result after k WAIT cycles, response.
  task automatic run_op(input string tag, input int ch, input fpu_op_t op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec,
                        input int k, input logic [31:0] y, input logic e);
    logic [3:0] exp_g;
    exp_g = 4'b0001 << ch;
    set_req(ch, op, a, b, c);
    #1;
    chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'(exp_g));
    tick();
    bus.req_valid = '0;
    chk({tag, ".start"}, 64'(bus.fpu_start), 64'd1);
    chk({tag, ".in_a"}, 64'(bus.fpu_in), 64'(ea));
    tick();
    chk({tag, ".start_b"}, 64'(bus.fpu_start), 64'd0);
    chk({tag, ".in_b"}, 64'(bus.fpu_in), 64'(eb));
    tick();
    chk({tag, ".in_c"}, 64'(bus.fpu_in), 64'(ec));
    tick();
    chk({tag, ".in_wait"}, 64'(bus.fpu_in), 64'd0);
    for (int i = 0; i < k; i++) tick();
    chk({tag, ".no_rsp_yet"}, 64'(bus.rsp_valid), 64'd0);
    bus.fpu_ready = 1'b1;
    bus.fpu_out   = y;
    bus.fpu_error = e;
    tick();
    bus.fpu_ready = 1'b0;
    bus.fpu_out   = '0;
    bus.fpu_error = 1'b0;
    chk({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({tag, ".rsp_ch"}, 64'(bus.rsp_ch), 64'(ch));
    chk({tag, ".rsp_y"}, 64'(bus.rsp_y), 64'(y));
    chk({tag, ".rsp_err"}, 64'(bus.rsp_err), 64'(e));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk({tag, ".idle_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, ".idle_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    logic [3:0] exp_g;
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
    bus.fpu_ready = 1'b0;
    bus.fpu_out   = '0;
    bus.fpu_error = 1'b0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst.start", 64'(bus.fpu_start), 64'd0);
    chk("rst.fpu_in", 64'(bus.fpu_in), 64'd0);
    chk("rst.rsp_y", 64'(bus.rsp_y), 64'd0);
    chk("rst.rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("rst.req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 1: FMA 2*3+1 on ch0
    run_op("fma", 0, FPU_FMA, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000,
           32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 4, 32'h40E0_0000, 1'b0);
    // 2: ADD 1.5+2.5 on ch1 maps to 1.0*a+b
    run_op("add", 1, FPU_ADD, 32'h3FC0_0000, 32'h4020_0000, 32'h1111_1111,
           32'h3F80_0000, 32'h3FC0_0000, 32'h4020_0000, 2, 32'h4080_0000, 1'b0);
    // MUL on ch2 with FPU exception flag
    run_op("mul_err", 2, FPU_MULTIPLY, 32'h4000_0000, 32'h4080_0000, 32'h1234_5678,
           32'h4000_0000, 32'h4080_0000, 32'h0000_0000, 0, 32'h4100_0000, 1'b1);

    // 4: FPU never answers on ch3
    set_req(3, FPU_FMA, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    tick();
    cnt = 0;
    while (!bus.rsp_valid && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("tmo.wait_cycles", 64'(cnt), 64'(TIMEOUT));
    chk("tmo.rsp_y", 64'(bus.rsp_y), 64'h7FC0_0000);
    chk("tmo.rsp_err", 64'(bus.rsp_err), 64'd1);
    chk("tmo.rsp_ch", 64'(bus.rsp_ch), 64'd3);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Ready arriving on the last WAIT cycle wins over the timeout
    run_op("tmo_edge", 0, FPU_FMA, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000,
           32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, TIMEOUT - 1, 32'h3F80_0000, 1'b0);

    // 5: back-pressure on the response, then a NOP
    set_req(2, FPU_MULTIPLY, 32'h4040_0000, 32'h40A0_0000, 32'hDEAD_BEEF);
    tick();
    bus.req_valid = '0;
    chk("bp.in_a", 64'(bus.fpu_in), 64'h4040_0000);
    tick();
    chk("bp.in_b", 64'(bus.fpu_in), 64'h40A0_0000);
    tick();
    chk("bp.in_c", 64'(bus.fpu_in), 64'h0);
    tick();
    bus.fpu_ready = 1'b1;
    bus.fpu_out   = 32'h4170_0000;
    tick();
    bus.fpu_ready = 1'b0;
    bus.fpu_out   = '0;
    set_req(1, FPU_NOP, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp.req_ready", 64'(bus.req_ready), 64'd0);
      chk("bp.rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp.rsp_y", 64'(bus.rsp_y), 64'h4170_0000);
      chk("bp.rsp_ch", 64'(bus.rsp_ch), 64'd2);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp.bubble", 64'(bus.req_ready), 64'd0);
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    chk("nop.req_ready", 64'(bus.req_ready), 64'b0010);
    tick();
    bus.req_valid = '0;
    chk("nop.rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("nop.rsp_y", 64'(bus.rsp_y), 64'd0);
    chk("nop.rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("nop.rsp_ch", 64'(bus.rsp_ch), 64'd1);
    chk("nop.start", 64'(bus.fpu_start), 64'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("nop.idle", 64'(bus.busy), 64'd0);

    // 6: reset during WAIT, then during SEND_A
    set_req(3, FPU_FMA, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    tick();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("rstw.busy", 64'(bus.busy), 64'd0);
    chk("rstw.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rstw.rsp_y", 64'(bus.rsp_y), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    set_req(1, FPU_FMA, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
    tick();
    bus.req_valid = '0;
    chk("rsts.start_before", 64'(bus.fpu_start), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rsts.start", 64'(bus.fpu_start), 64'd0);
    chk("rsts.fpu_in", 64'(bus.fpu_in), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rsts.no_stale", 64'(bus.rsp_valid), 64'd0);

    // Pointer back at reset value: all-valid arbitration yields 0,1,2,3,0
    for (int ch = 0; ch < NUM_CH; ch++) set_req(ch, FPU_NOP, 32'h0, 32'h0, 32'h0);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % NUM_CH);
      cnt = 0;
      #1;
      while (bus.req_ready == 4'b0000 && cnt < 10) begin
        tick();
        cnt++;
      end
      chk("rr.grant", 64'(bus.req_ready), 64'(exp_g));
      tick();
      chk("rr.rsp_ch", 64'(bus.rsp_ch), 64'(k % NUM_CH));
    end
    bus.req_valid = '0;
    tick();
    bus.rsp_ready = 1'b0;

    // Normal FMA after the resets
    run_op("post_rst", 0, FPU_FMA, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000,
           32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 4, 32'h40E0_0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
